// File: rtl/pwl_filter_sched_pkg.sv
// Shared types for the PWL filter reconfiguration scheduler: FSM state encoding,
// the stored coefficient record and its reset default.
package pwl_filter_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_RST    = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Reals are held as IEEE-754 bit patterns so the table stays a plain packed array.
  typedef struct packed {
    logic [63:0] wz1;
    logic [63:0] wp1;
    logic [63:0] wp2;
    logic [1:0]  ftype;
    logic        cplx;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    wz1:   64'h3FF0_0000_0000_0000,
    wp1:   64'h3FF0_0000_0000_0000,
    wp2:   64'h4000_0000_0000_0000,
    ftype: 2'd0,
    cplx:  1'b0
  };

  function automatic logic [1:0] sanitize_type(input integer t);
    logic [1:0] r;
    if ((t >= 32'sd0) && (t <= 32'sd3)) begin
      r = t[1:0];
    end else begin
      r = 2'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwl_filter_sched_if.sv
// Requester handshake, table write port and filter drive bundle of the scheduler.
interface pwl_filter_sched_if #(
  parameter int NREQ = 4,
  parameter int NCFG = 8
);
  localparam int IW = (NCFG > 1) ? $clog2(NCFG) : 1;

  logic [NREQ-1:0]          req;
  logic [NREQ-1:0][IW-1:0]  req_idx;
  logic [NREQ-1:0]          req_rst;
  logic [NREQ-1:0]          gnt;
  logic [NREQ-1:0]          ack;
  logic                     busy;

  logic                     wr_en;
  logic [IW-1:0]            wr_addr;
  real                      wr_wz1;
  real                      wr_wp1;
  real                      wr_wp2;
  integer                   wr_type;
  logic                     wr_cplx;

  real                      wz1;
  real                      wp1;
  real                      wp2;
  integer                   filter_type;
  logic                     en_complex;
  logic                     hold;
  logic                     filt_reset;

  modport master (
    output req, req_idx, req_rst, wr_en, wr_addr, wr_wz1, wr_wp1, wr_wp2, wr_type, wr_cplx,
    input  gnt, ack, busy, wz1, wp1, wp2, filter_type, en_complex, hold, filt_reset
  );

  modport slave (
    input  req, req_idx, req_rst, wr_en, wr_addr, wr_wz1, wr_wp1, wr_wp2, wr_type, wr_cplx,
    output gnt, ack, busy, wz1, wp1, wp2, filter_type, en_complex, hold, filt_reset
  );
endinterface

// File: rtl/pwl_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the
// winner only when upd is asserted.
module pwl_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  output logic [NREQ-1:0] gnt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_r;
  logic          found_s;
  int            win_s;

  // Search from the pointer, wrapping, and take the first active request.
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    win_s   = 0;
    for (int i = 0; i < NREQ; i++) begin
      int  k;
      logic take;
      k    = (int'(ptr_r) + i) % NREQ;
      take = !found_s && req[k];
      gnt[k]  = take;
      win_s   = take ? k : win_s;
      found_s = found_s | take;
    end
  end

  // Pointer moves to the requester after the winner on each accepted grant.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_r <= '0;
    end else if (upd && found_s) begin
      ptr_r <= PW'((win_s + 1) % NREQ);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/pwl_filter_sched.sv
// Shares one PWL filter among NREQ requesters: arbitrates, holds the filter,
// loads coefficients from a table, optionally pulses reset, settles, acknowledges.
module pwl_filter_sched
  import pwl_filter_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int NCFG       = 8,
  parameter int HOLD_CYC   = 2,
  parameter int SETTLE_CYC = 4
) (
  input logic               clk,
  input logic               rstn,
  pwl_filter_sched_if.slave bus
);
  localparam int IW = (NCFG > 1) ? $clog2(NCFG) : 1;

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_HOLD   = ST_HOLD;
  localparam logic [2:0] S_LOAD   = ST_LOAD;
  localparam logic [2:0] S_RST    = ST_RST;
  localparam logic [2:0] S_SETTLE = ST_SETTLE;
  localparam logic [2:0] S_DONE   = ST_DONE;

  logic [2:0]      state_r, state_nxt_s;
  logic [7:0]      cnt_r, cnt_nxt_s;
  logic [NREQ-1:0] arb_gnt_s, gnt_r, ack_r;
  logic            busy_r, hold_r, filt_reset_r;
  logic [IW-1:0]   idx_r, win_idx_s;
  logic            rst_flag_r, win_rst_s, grant_s;
  cfg_t            tbl_r [NCFG];
  cfg_t            coef_r, rd_s, wr_cfg_s;

  assign grant_s = (state_r == S_IDLE) && (|bus.req);

  pwl_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  (bus.req),
    .upd  (grant_s),
    .gnt  (arb_gnt_s)
  );

  // Index and reset flag of the arbitration winner (grant is one-hot).
  always_comb begin
    win_idx_s = '0;
    win_rst_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      win_idx_s = win_idx_s | (bus.req_idx[i] & {IW{arb_gnt_s[i]}});
      win_rst_s = win_rst_s | (bus.req_rst[i] & arb_gnt_s[i]);
    end
  end

  // Table read for LOAD and write-data formatting.
  always_comb begin
    if (int'(idx_r) < NCFG) begin
      rd_s = tbl_r[idx_r];
    end else begin
      rd_s = CFG_DEFAULT;
    end
    wr_cfg_s.wz1   = $realtobits(bus.wr_wz1);
    wr_cfg_s.wp1   = $realtobits(bus.wr_wp1);
    wr_cfg_s.wp2   = $realtobits(bus.wr_wp2);
    wr_cfg_s.ftype = sanitize_type(bus.wr_type);
    wr_cfg_s.cplx  = bus.wr_cplx;
  end

  // Sequencer next state and phase counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (|bus.req) begin
          state_nxt_s = S_HOLD;
          cnt_nxt_s   = 8'(HOLD_CYC - 1);
        end else begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = 8'd0;
        end
      end
      S_HOLD: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = S_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      S_LOAD: begin
        if (rst_flag_r) begin
          state_nxt_s = S_RST;
        end else begin
          state_nxt_s = S_SETTLE;
          cnt_nxt_s   = 8'(SETTLE_CYC - 1);
        end
      end
      S_RST: begin
        state_nxt_s = S_SETTLE;
        cnt_nxt_s   = 8'(SETTLE_CYC - 1);
      end
      S_SETTLE: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = S_DONE;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 8'd0;
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // State, registered outputs (decoded from next state), table and coefficients.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= S_IDLE;
      cnt_r        <= 8'd0;
      gnt_r        <= '0;
      ack_r        <= '0;
      busy_r       <= 1'b0;
      hold_r       <= 1'b0;
      filt_reset_r <= 1'b0;
      idx_r        <= '0;
      rst_flag_r   <= 1'b0;
      coef_r       <= CFG_DEFAULT;
      for (int i = 0; i < NCFG; i++) begin
        tbl_r[i] <= CFG_DEFAULT;
      end
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      busy_r       <= (state_nxt_s != S_IDLE);
      hold_r       <= (state_nxt_s == S_HOLD) || (state_nxt_s == S_LOAD);
      filt_reset_r <= (state_nxt_s == S_RST);
      ack_r        <= (state_nxt_s == S_DONE) ? gnt_r : '0;
      if (state_nxt_s == S_IDLE) begin
        gnt_r <= '0;
      end else if (state_r == S_IDLE) begin
        gnt_r <= arb_gnt_s;
      end else begin
        gnt_r <= gnt_r;
      end
      if (grant_s) begin
        idx_r      <= win_idx_s;
        rst_flag_r <= win_rst_s;
      end
      if (state_r == S_LOAD) begin
        coef_r <= rd_s;
      end
      // Same-edge write to the entry being loaded: the load sees the old value.
      if (bus.wr_en && (int'(bus.wr_addr) < NCFG)) begin
        tbl_r[bus.wr_addr] <= wr_cfg_s;
      end
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.ack         = ack_r;
  assign bus.busy        = busy_r;
  assign bus.hold        = hold_r;
  assign bus.filt_reset  = filt_reset_r;
  assign bus.wz1         = $bitstoreal(coef_r.wz1);
  assign bus.wp1         = $bitstoreal(coef_r.wp1);
  assign bus.wp2         = $bitstoreal(coef_r.wp2);
  assign bus.filter_type = {30'd0, coef_r.ftype};
  assign bus.en_complex  = coef_r.cplx;

endmodule

// File: tb/tb_pwl_filter_sched.sv
// Self-checking bench for pwl_filter_sched: vector table of single sequences,
// ack scoreboard, and hand sequences for mid-sequence reset and round-robin order.
module tb_pwl_filter_sched;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pwl_filter_sched_if #(.NREQ(4), .NCFG(8)) bus ();

  pwl_filter_sched #(.NREQ(4), .NCFG(8), .HOLD_CYC(2), .SETTLE_CYC(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int  rq;
    int  idx;
    bit  rst;
    int  exp_ack;
    int  exp_frst;
    int  exp_type;
    bit  exp_cplx;
    int  drop_k;
    bit  wload;
  } vec_t;

  typedef struct {
    int  rq;
    real wp1;
  } sb_t;

  int    checks   = 0;
  int    failures = 0;
  sb_t   q[$];
  real   tb_wp1[8];
  real   cur_wp1;
  vec_t  vecs[6];

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_real(input string name, input real act, input real exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%g required=%g", name, act, exp);
    end
  endtask

  // Scoreboard: every ack pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (bus.ack !== 4'b0000) begin
      if (q.size() == 0) begin
        chk_int("ack_unexpected", int'(bus.ack), 0);
      end else begin
        sb_t e;
        e = q.pop_front();
        chk_int("sb_ack", int'(bus.ack), 1 << e.rq);
        chk_real("sb_wp1", bus.wp1, e.wp1);
      end
    end
  end

  task automatic apply_reset();
    rstn = 1'b0;
    bus.req = 4'b0000;
    bus.wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) tb_wp1[i] = 1.0;
    cur_wp1 = 1.0;
  endtask

  task automatic wr(input int a, input real z, input real p1, input real p2,
                    input int t, input bit c);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(a);
    bus.wr_wz1  = z;
    bus.wr_wp1  = p1;
    bus.wr_wp2  = p2;
    bus.wr_type = t;
    bus.wr_cplx = c;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    tb_wp1[a] = p1;
  endtask

  task automatic run_vec(input vec_t v);
    real saved;
    saved = tb_wp1[v.idx];
    bus.req_idx[v.rq] = 3'(v.idx);
    bus.req_rst[v.rq] = v.rst;
    bus.req = 4'(1 << v.rq);
    q.push_back('{v.rq, saved});
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) cur_wp1 = saved;
      chk_int($sformatf("gnt_r%0d_c%0d", v.rq, k), int'(bus.gnt), (k <= v.exp_ack) ? (1 << v.rq) : 0);
      chk_int($sformatf("hold_c%0d", k), int'(bus.hold), (k <= 3) ? 1 : 0);
      chk_int($sformatf("frst_c%0d", k), int'(bus.filt_reset), (k == v.exp_frst) ? 1 : 0);
      chk_int($sformatf("busy_c%0d", k), int'(bus.busy), (k <= v.exp_ack) ? 1 : 0);
      chk_real($sformatf("wp1_c%0d", k), bus.wp1, cur_wp1);
      if (k == 4) begin
        chk_int("ftype_c4", bus.filter_type, v.exp_type);
        chk_int("cplx_c4", int'(bus.en_complex), int'(v.exp_cplx));
      end
      if (k == v.drop_k) bus.req = 4'b0000;
      if (v.wload && k == 3) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(v.idx);
        bus.wr_wz1  = 1.0e3;
        bus.wr_wp1  = 7.0e9;
        bus.wr_wp2  = 6.0e9;
        bus.wr_type = 1;
        bus.wr_cplx = 1'b0;
        tb_wp1[v.idx] = 7.0e9;
      end
      if (v.wload && k == 4) bus.wr_en = 1'b0;
    end
  endtask

  initial begin
    int gcount;
    int gwho[5];
    int gcyc[5];
    int exp_order[5];
    int cyc;
    logic [3:0] prev;

    bus.req = 4'b0000; bus.req_idx = '0; bus.req_rst = 4'b0000;
    bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_wz1 = 0.0; bus.wr_wp1 = 0.0;
    bus.wr_wp2 = 0.0; bus.wr_type = 0; bus.wr_cplx = 1'b0;

    vecs[0] = '{1, 3, 0, 8, 0, 1, 0, 1, 0};
    vecs[1] = '{2, 2, 1, 9, 4, 2, 1, 1, 0};
    vecs[2] = '{0, 5, 0, 8, 0, 0, 1, 2, 0};
    vecs[3] = '{3, 1, 1, 9, 4, 3, 0, 1, 0};
    vecs[4] = '{1, 3, 0, 8, 0, 1, 0, 1, 1};
    vecs[5] = '{0, 3, 0, 8, 0, 1, 0, 1, 0};

    // Reset values
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_int("rst_gnt", int'(bus.gnt), 0);
    chk_int("rst_ack", int'(bus.ack), 0);
    chk_int("rst_busy", int'(bus.busy), 0);
    chk_int("rst_hold", int'(bus.hold), 0);
    chk_int("rst_frst", int'(bus.filt_reset), 0);
    chk_real("rst_wz1", bus.wz1, 1.0);
    chk_real("rst_wp1", bus.wp1, 1.0);
    chk_real("rst_wp2", bus.wp2, 2.0);
    chk_int("rst_type", bus.filter_type, 0);
    chk_int("rst_cplx", int'(bus.en_complex), 0);
    apply_reset();

    wr(3, 1.0e3, 5.0e9, 6.0e9, 1, 1'b0);
    wr(2, 2.0e3, 4.0e9, 8.0e9, 2, 1'b1);
    wr(5, 3.0e3, 9.0e8, 9.0e9, 7, 1'b1);
    wr(1, 4.0e3, 3.0e9, 1.0e10, 3, 1'b0);
    chk_real("wr_no_effect_wp1", bus.wp1, 1.0);
    chk_int("wr_no_effect_busy", int'(bus.busy), 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end
    chk_real("load_wz1", bus.wz1, 1.0e3);
    chk_real("load_wp2", bus.wp2, 6.0e9);

    // Reset in the middle of a sequence
    bus.req_idx[0] = 3'd3; bus.req_rst[0] = 1'b0; bus.req = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) chk_real("mrst_wp1_c4", bus.wp1, 7.0e9);
    end
    rstn = 1'b0;
    bus.req = 4'b0000;
    @(posedge clk);
    #1;
    chk_int("mrst_hold", int'(bus.hold), 0);
    chk_int("mrst_gnt", int'(bus.gnt), 0);
    chk_int("mrst_busy", int'(bus.busy), 0);
    chk_int("mrst_frst", int'(bus.filt_reset), 0);
    chk_real("mrst_wp1", bus.wp1, 1.0);
    chk_real("mrst_wp2", bus.wp2, 2.0);
    rstn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    apply_reset();

    // Round-robin with all requesters held
    for (int i = 0; i < 4; i++) begin
      wr(i, 1.0e3, real'(i + 1) * 1.0e9, 2.0, 0, 1'b0);
      bus.req_idx[i] = 3'(i);
      bus.req_rst[i] = 1'b0;
    end
    exp_order = '{0, 1, 2, 3, 0};
    for (int j = 0; j < 5; j++) q.push_back('{exp_order[j], tb_wp1[exp_order[j]]});
    bus.req = 4'b1111;
    gcount = 0; cyc = 0; prev = 4'b0000;
    while (cyc < 80 && !(gcount == 5 && bus.busy == 1'b0)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.gnt != 4'b0000 && prev == 4'b0000 && gcount < 5) begin
        gwho[gcount] = -1;
        for (int b = 0; b < 4; b++) if (bus.gnt == 4'(1 << b)) gwho[gcount] = b;
        gcyc[gcount] = cyc;
        gcount++;
        if (gcount == 5) bus.req = 4'b0000;
      end
      prev = bus.gnt;
    end
    if (gcount < 5 || bus.busy != 1'b0) begin
      chk_int("rr_timeout_grants", gcount, 6);
    end else begin
      for (int j = 0; j < 5; j++) begin
        chk_int($sformatf("rr_order%0d", j), gwho[j], exp_order[j]);
        if (j > 0) chk_int($sformatf("rr_gap%0d", j), gcyc[j] - gcyc[j-1], 9);
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk_int("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
